// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/redirect controller: FSM states, register index type,
// and a saturating counter helper used by the optional HAZARD_STATS_EN statistics.
package pipe_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_FLUSH = 1'b1
   } hz_state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID issue / MA completion / EX redirect bundle between the pipeline and the hazard controller.
// Statistics counters exist only when HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
   parameter int REG_SZ = 32
);
   import pipe_hazard_ctrl_pkg::*;

   logic              id_valid;
   logic              id_ready;
   reg_idx_t          id_rs1;
   reg_idx_t          id_rs2;
   reg_idx_t          id_rd;
   logic              id_wb_e;
   logic              id_ld_e;
   logic              ma_done;
   reg_idx_t          ma_idx;
   logic              jp_e;
   logic [REG_SZ-1:0] jp_pc;
   logic              pc_we;
   logic [REG_SZ-1:0] pc_out;
   logic              flush;
   logic [31:0]       busy_mask;
`ifdef HAZARD_STATS_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       flush_cnt;
`endif

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_wb_e, id_ld_e,
      output ma_done, ma_idx, jp_e, jp_pc,
      input  id_ready, pc_we, pc_out, flush, busy_mask
`ifdef HAZARD_STATS_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_wb_e, id_ld_e,
      input  ma_done, ma_idx, jp_e, jp_pc,
      output id_ready, pc_we, pc_out, flush, busy_mask
`ifdef HAZARD_STATS_EN
      , output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Load scoreboard: one busy bit per architectural register plus an outstanding-load count.
// Answers the issue hazard query from registered state only (no same-cycle clear bypass).
module pipe_hazard_ctrl_scoreboard
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MAX_LD = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_e,
   input  reg_idx_t    set_idx,
   input  logic        clr_e,
   input  reg_idx_t    clr_idx,
   input  reg_idx_t    q_rs1,
   input  reg_idx_t    q_rs2,
   input  reg_idx_t    q_rd,
   input  logic        q_wb_e,
   input  logic        q_ld_e,
   output logic        hazard,
   output logic [31:0] busy_mask
);
   localparam int CNT_W = $clog2(MAX_LD + 1);

   logic [CNT_W-1:0] ld_cnt;
   logic             set_ok;
   logic             clr_ok;
   logic [31:0]      set_mask;
   logic [31:0]      clr_mask;

   // Completions for idle or x0 entries are dropped so ld_cnt stays in step with busy_mask.
   always_comb begin
      set_ok   = set_e & (set_idx != '0);
      clr_ok   = clr_e & (clr_idx != '0) & busy_mask[clr_idx];
      set_mask = '0;
      clr_mask = '0;
      if (set_ok) set_mask[set_idx] = 1'b1;
      if (clr_ok) clr_mask[clr_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_mask <= '0;
         ld_cnt    <= '0;
      end else begin
         busy_mask <= ((busy_mask & ~clr_mask) | set_mask) & ~32'd1;
         case ({set_ok, clr_ok})
            2'b10:   ld_cnt <= ld_cnt + 1'b1;
            2'b01:   ld_cnt <= ld_cnt - 1'b1;
            default: ld_cnt <= ld_cnt;
         endcase
      end
   end

   always_comb begin
      hazard = ((q_rs1 != '0) & busy_mask[q_rs1])
             | ((q_rs2 != '0) & busy_mask[q_rs2])
             | (q_wb_e & (q_rd != '0) & busy_mask[q_rd])
             | (q_ld_e & (ld_cnt == CNT_W'(MAX_LD)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect controller: gates ID issue on the load scoreboard, turns an EX jump into
// a registered PC write plus a FLUSH_LEN-cycle IF/ID flush. Optional stats via HAZARD_STATS_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_SZ    = 32,
   parameter int MAX_LD    = 2,
   parameter int FLUSH_LEN = 2
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int FCNT_W = $clog2(FLUSH_LEN + 1);

   hz_state_t         state;
   hz_state_t         state_nxt;
   logic [FCNT_W-1:0] fcnt;
   logic              hazard;
   logic              id_ready;
   logic              flush;
   logic              issue;
   logic              pc_we_q;
   logic [REG_SZ-1:0] pc_q;
   logic [31:0]       busy_mask;

   assign issue = bus.id_valid & id_ready;

   pipe_hazard_ctrl_scoreboard #(
      .MAX_LD (MAX_LD)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_e     (issue & bus.id_ld_e & bus.id_wb_e),
      .set_idx   (bus.id_rd),
      .clr_e     (bus.ma_done),
      .clr_idx   (bus.ma_idx),
      .q_rs1     (bus.id_rs1),
      .q_rs2     (bus.id_rs2),
      .q_rd      (bus.id_rd),
      .q_wb_e    (bus.id_wb_e),
      .q_ld_e    (bus.id_ld_e),
      .hazard    (hazard),
      .busy_mask (busy_mask)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HZ_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HZ_RUN:   if (bus.jp_e) state_nxt = HZ_FLUSH;
         HZ_FLUSH: if (!bus.jp_e && fcnt == '0) state_nxt = HZ_RUN;
         default:  state_nxt = HZ_RUN;
      endcase
   end

   always_comb begin
      flush    = (state == HZ_FLUSH);
      id_ready = (state == HZ_RUN) & ~bus.jp_e & ~hazard;
   end

   // A jump while already flushing restarts the window and replaces the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt    <= '0;
         pc_we_q <= 1'b0;
         pc_q    <= '0;
      end else begin
         pc_we_q <= bus.jp_e;
         if (bus.jp_e) begin
            fcnt <= FCNT_W'(FLUSH_LEN - 1);
            pc_q <= bus.jp_pc;
         end else if (state == HZ_FLUSH && fcnt != '0) begin
            fcnt <= fcnt - 1'b1;
         end
      end
   end

   assign bus.id_ready  = id_ready;
   assign bus.flush     = flush;
   assign bus.pc_we     = pc_we_q;
   assign bus.pc_out    = pc_q;
   assign bus.busy_mask = busy_mask;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (bus.id_valid & ~id_ready & (state == HZ_RUN)) stall_q <= sat_inc32(stall_q);
         if (bus.jp_e) flush_q <= sat_inc32(flush_q);
      end
   end

   assign bus.stall_cnt = stall_q;
   assign bus.flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, a reset-during-flush sequence,
// and randomized traffic against a queue-based reference model.
module tb_pipe_hazard_ctrl;
   localparam int MAX_LD    = 2;
   localparam int FLUSH_LEN = 2;

   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic        wb, ld, ma;
      logic [4:0]  midx;
      logic        jp;
      logic [31:0] jppc;
      logic        rdy;
      logic [31:0] busy;
      logic        fl, pcwe;
      logic [31:0] pc;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   pipe_hazard_ctrl_if #(.REG_SZ(32)) bus ();

   pipe_hazard_ctrl #(
      .REG_SZ    (32),
      .MAX_LD    (MAX_LD),
      .FLUSH_LEN (FLUSH_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: outstanding loads kept as a queue of destination registers.
   int          ld_q[$];
   int          flush_left;
   logic        pcwe_m;
   logic [31:0] pc_m;
   longint      stall_m;
   longint      jmp_m;

   function automatic vec_t mk(input logic valid, input int rs1, input int rs2, input int rd,
                               input logic wb, input logic ld, input logic ma, input int midx,
                               input logic jp, input int jppc, input logic rdy, input int busy,
                               input logic fl, input logic pcwe, input int pc);
      vec_t v;
      v.valid = valid; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
      v.wb = wb; v.ld = ld; v.ma = ma; v.midx = 5'(midx);
      v.jp = jp; v.jppc = 32'(jppc);
      v.rdy = rdy; v.busy = 32'(busy); v.fl = fl; v.pcwe = pcwe; v.pc = 32'(pc);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic valid, input int rs1, input int rs2, input int rd,
                         input logic wb, input logic ld, input logic ma, input int midx,
                         input logic jp, input logic [31:0] jppc);
      bus.id_valid = valid;
      bus.id_rs1   = 5'(rs1);
      bus.id_rs2   = 5'(rs2);
      bus.id_rd    = 5'(rd);
      bus.id_wb_e  = wb;
      bus.id_ld_e  = ld;
      bus.ma_done  = ma;
      bus.ma_idx   = 5'(midx);
      bus.jp_e     = jp;
      bus.jp_pc    = jppc;
   endtask

   function automatic bit outstanding(input int r);
      foreach (ld_q[i]) if (ld_q[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (ld_q[i]) m[ld_q[i]] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      ld_q.delete();
      flush_left = 0;
      pcwe_m     = 1'b0;
      pc_m       = '0;
      stall_m    = 0;
      jmp_m      = 0;
   endtask

   function automatic bit model_ready();
      bit haz;
      haz = (bus.id_rs1 != 0 && outstanding(int'(bus.id_rs1)))
         || (bus.id_rs2 != 0 && outstanding(int'(bus.id_rs2)))
         || (bus.id_wb_e && bus.id_rd != 0 && outstanding(int'(bus.id_rd)))
         || (bus.id_ld_e && ld_q.size() == MAX_LD);
      return (flush_left == 0) && !bus.jp_e && !haz;
   endfunction

   task automatic model_step(input bit rdy);
      if (bus.id_valid && !rdy && flush_left == 0) stall_m++;
      if (bus.ma_done && bus.ma_idx != 0) begin
         foreach (ld_q[i]) if (ld_q[i] == int'(bus.ma_idx)) begin
            ld_q.delete(i);
            break;
         end
      end
      if (bus.id_valid && rdy && bus.id_ld_e && bus.id_wb_e && bus.id_rd != 0)
         ld_q.push_back(int'(bus.id_rd));
      if (bus.jp_e) begin
         jmp_m++;
         pcwe_m     = 1'b1;
         pc_m       = bus.jp_pc;
         flush_left = FLUSH_LEN;
      end else begin
         pcwe_m = 1'b0;
         if (flush_left > 0) flush_left--;
      end
   endtask

   vec_t tbl[27];

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();

      tbl[0]  = mk(1,0,0,5,1,1, 0,0, 0,0,     1,'h000, 0,0,'h00);
      tbl[1]  = mk(1,5,0,6,1,0, 0,0, 0,0,     0,'h020, 0,0,'h00);
      tbl[2]  = mk(1,5,0,6,1,0, 1,5, 0,0,     0,'h020, 0,0,'h00);
      tbl[3]  = mk(1,5,0,6,1,0, 0,0, 0,0,     1,'h000, 0,0,'h00);
      tbl[4]  = mk(1,0,0,1,1,1, 0,0, 0,0,     1,'h000, 0,0,'h00);
      tbl[5]  = mk(1,0,0,2,1,1, 0,0, 0,0,     1,'h002, 0,0,'h00);
      tbl[6]  = mk(1,0,0,3,1,1, 0,0, 0,0,     0,'h006, 0,0,'h00);
      tbl[7]  = mk(1,0,0,3,1,1, 1,1, 0,0,     0,'h006, 0,0,'h00);
      tbl[8]  = mk(1,0,0,3,1,1, 0,0, 0,0,     1,'h004, 0,0,'h00);
      tbl[9]  = mk(0,0,0,0,0,0, 1,3, 0,0,     1,'h00C, 0,0,'h00);
      tbl[10] = mk(1,0,0,7,1,1, 1,2, 0,0,     1,'h004, 0,0,'h00);
      tbl[11] = mk(1,0,0,8,1,1, 0,0, 0,0,     1,'h080, 0,0,'h00);
      tbl[12] = mk(1,0,0,9,1,1, 0,0, 0,0,     0,'h180, 0,0,'h00);
      tbl[13] = mk(1,0,0,9,1,1, 1,0, 0,0,     0,'h180, 0,0,'h00);
      tbl[14] = mk(0,0,0,0,0,0, 1,7, 0,0,     1,'h180, 0,0,'h00);
      tbl[15] = mk(0,0,0,0,0,0, 1,8, 0,0,     1,'h100, 0,0,'h00);
      tbl[16] = mk(1,0,0,5,1,1, 0,0, 0,0,     1,'h000, 0,0,'h00);
      tbl[17] = mk(0,0,0,0,0,0, 0,0, 1,'h40,  0,'h020, 0,0,'h00);
      tbl[18] = mk(1,1,0,2,1,0, 0,0, 0,0,     0,'h020, 1,1,'h40);
      tbl[19] = mk(1,1,0,2,1,0, 0,0, 0,0,     0,'h020, 1,0,'h40);
      tbl[20] = mk(1,1,0,2,1,0, 0,0, 0,0,     1,'h020, 0,0,'h40);
      tbl[21] = mk(0,0,0,0,0,0, 0,0, 1,'h80,  0,'h020, 0,0,'h40);
      tbl[22] = mk(0,0,0,0,0,0, 0,0, 0,0,     0,'h020, 1,1,'h80);
      tbl[23] = mk(0,0,0,0,0,0, 0,0, 1,'hC0,  0,'h020, 1,0,'h80);
      tbl[24] = mk(0,0,0,0,0,0, 0,0, 0,0,     0,'h020, 1,1,'hC0);
      tbl[25] = mk(0,0,0,0,0,0, 0,0, 0,0,     0,'h020, 1,0,'hC0);
      tbl[26] = mk(0,0,0,0,0,0, 0,0, 0,0,     1,'h020, 0,0,'hC0);

      // Reset state
      rst = 1'b1;
      set_in(0,0,0,0,0,0,0,0,0,'0);
      #12;
      chk("rst_ready", 32'(bus.id_ready), 32'd1);
      chk("rst_busy",  bus.busy_mask, 32'd0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_pcwe",  32'(bus.pc_we), 32'd0);
      chk("rst_pc",    bus.pc_out, 32'd0);
`ifdef HAZARD_STATS_EN
      chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
      chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 27; i++) begin
         set_in(tbl[i].valid, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
                tbl[i].wb, tbl[i].ld, tbl[i].ma, int'(tbl[i].midx), tbl[i].jp, tbl[i].jppc);
         #3;
         chk($sformatf("tbl%0d_ready", i), 32'(bus.id_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_busy", i),  bus.busy_mask, tbl[i].busy);
         chk($sformatf("tbl%0d_flush", i), 32'(bus.flush), 32'(tbl[i].fl));
         chk($sformatf("tbl%0d_pcwe", i),  32'(bus.pc_we), 32'(tbl[i].pcwe));
         chk($sformatf("tbl%0d_pc", i),    bus.pc_out, tbl[i].pc);
         @(posedge clk); #1;
      end

      // Asynchronous reset in the middle of a flush with x5 outstanding
      set_in(0,0,0,0,0,0,0,0,1,32'h40);
      #3;
      @(posedge clk); #1;
      set_in(0,0,0,0,0,0,0,0,0,'0);
      #1;
      chk("pre_rst_flush", 32'(bus.flush), 32'd1);
      chk("pre_rst_busy",  bus.busy_mask, 32'h20);
      rst = 1'b1;
      #1;
      chk("mid_rst_flush", 32'(bus.flush), 32'd0);
      chk("mid_rst_busy",  bus.busy_mask, 32'd0);
      chk("mid_rst_pcwe",  32'(bus.pc_we), 32'd0);
      chk("mid_rst_pc",    bus.pc_out, 32'd0);
      chk("mid_rst_ready", 32'(bus.id_ready), 32'd1);
`ifdef HAZARD_STATS_EN
      chk("mid_rst_stall_cnt", bus.stall_cnt, 32'd0);
      chk("mid_rst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      set_in(0,0,0,0,0,0,1,5,0,'0);
      #3;
      chk("post_rst_stale_ma_busy", bus.busy_mask, 32'd0);
      @(posedge clk); #1;
      set_in(1,5,0,6,1,1,0,0,0,'0);
      #3;
      chk("post_rst_ready", 32'(bus.id_ready), 32'd1);
      chk("post_rst_flush", 32'(bus.flush), 32'd0);
      @(posedge clk); #1;
      set_in(1,6,0,7,1,0,0,0,0,'0);
      #3;
      chk("post_rst_count_ok", bus.busy_mask, 32'h40);
      chk("post_rst_dep_stall", 32'(bus.id_ready), 32'd0);

      // Randomized traffic against the reference model
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit rdy;
         set_in($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
                $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
                $urandom_range(7), $urandom_range(11) == 0, $urandom);
         #3;
         rdy = model_ready();
         chk("rnd_ready", 32'(bus.id_ready), 32'(rdy));
         chk("rnd_busy",  bus.busy_mask, model_mask());
         chk("rnd_flush", 32'(bus.flush), 32'(flush_left > 0));
         chk("rnd_pcwe",  32'(bus.pc_we), 32'(pcwe_m));
         chk("rnd_pc",    bus.pc_out, pc_m);
`ifdef HAZARD_STATS_EN
         chk("rnd_stall_cnt", bus.stall_cnt, 32'(stall_m));
         chk("rnd_flush_cnt", bus.flush_cnt, 32'(jmp_m));
`endif
         model_step(rdy);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
